// File: rtl/clq_store_pkg.sv
// Shared types and sizing for the clause-list store and its consumers.
// The literal-to-table-index map is reused by the GST.
package clq_store_pkg;

  localparam int unsigned NODE_DEPTH  = 64;
  localparam int unsigned CLA_LENGTH  = 3;
  localparam int unsigned LIT_IDX_MAX = 16;

  localparam int unsigned LIT_W     = $clog2(LIT_IDX_MAX) + 1;
  localparam int unsigned PTR_W     = $clog2(NODE_DEPTH);
  localparam int unsigned NF_W      = $clog2(NODE_DEPTH) + 1;
  localparam int unsigned TBL_DEPTH = 2 * LIT_IDX_MAX + 2;
  localparam int unsigned TIDX_W    = $clog2(TBL_DEPTH);
  localparam int unsigned SLOT_W    = (CLA_LENGTH > 1) ? $clog2(CLA_LENGTH) : 1;

  typedef logic signed [LIT_W-1:0] lit_t;
  typedef logic [PTR_W-1:0]        ptr_t;
  typedef logic [SLOT_W-1:0]       slot_t;
  typedef logic [TIDX_W-1:0]       tidx_t;
  typedef lit_t [CLA_LENGTH-1:0]   cla_t;

  typedef struct packed {
    cla_t                   cla;
    ptr_t [CLA_LENGTH-1:0]  ptr;
  } node_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LINK = 1'b1
  } clq_state_e;

  // +v -> 2v, -v -> 2v+1; widened first so that the most negative literal negates cleanly.
  function automatic tidx_t lit_idx(input lit_t l);
    logic signed [LIT_W:0] w;
    logic [LIT_W:0]        mag;
    w   = {l[LIT_W-1], l};
    mag = w[LIT_W] ? -w : w;
    return tidx_t'({mag, w[LIT_W]});
  endfunction

endpackage

// File: rtl/clq_store_if.sv
// CArb insert and BCP lookup signals of the clause-list store.
interface clq_store_if;
  import clq_store_pkg::*;

  cla_t  carb2clq_cla;
  logic  carb2clq_valid;
  logic  clq2carb_ready;
  logic  halt;
  logic  full;
  lit_t  bcp2clq_lit;
  ptr_t  clq2bcp_init_ptr;
  logic  clq2bcp_init_ptr_valid;
  ptr_t  node_ptr;
  node_t node;

  modport master (
    output carb2clq_cla, carb2clq_valid, bcp2clq_lit, node_ptr,
    input  clq2carb_ready, halt, full, clq2bcp_init_ptr, clq2bcp_init_ptr_valid, node
  );

  modport slave (
    input  carb2clq_cla, carb2clq_valid, bcp2clq_lit, node_ptr,
    output clq2carb_ready, halt, full, clq2bcp_init_ptr, clq2bcp_init_ptr_valid, node
  );
endinterface

// File: rtl/clq_lit_table.sv
// Per-literal watch-list head/tail/tail_slot registers.
// Combinational head and tail read ports, one write port, synchronous clear.
module clq_lit_table
  import clq_store_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  tidx_t rd_head_idx,
  output ptr_t  rd_head,
  input  tidx_t rd_tail_idx,
  output ptr_t  rd_tail,
  output slot_t rd_tail_slot,
  input  logic  we,
  input  tidx_t wr_idx,
  input  logic  wr_head,
  input  ptr_t  wr_ptr,
  input  slot_t wr_slot
);

  ptr_t  head      [TBL_DEPTH];
  ptr_t  tail      [TBL_DEPTH];
  slot_t tail_slot [TBL_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int unsigned k = 0; k < TBL_DEPTH; k++) begin
        head[k]      <= '0;
        tail[k]      <= '0;
        tail_slot[k] <= '0;
      end
    end else if (we) begin
      if (wr_head) head[wr_idx] <= wr_ptr;
      tail[wr_idx]      <= wr_ptr;
      tail_slot[wr_idx] <= wr_slot;
    end
  end

  assign rd_head      = head[rd_head_idx];
  assign rd_tail      = tail[rd_tail_idx];
  assign rd_tail_slot = tail_slot[rd_tail_idx];

endmodule

// File: rtl/clq_store.sv
// Clause-list store: allocates clause nodes and threads each one onto a
// per-literal watch list, one clause slot per cycle, halting BCP meanwhile.
module clq_store
  import clq_store_pkg::*;
#(
  parameter int unsigned NODE_DEPTH = clq_store_pkg::NODE_DEPTH
)(
  input logic        clk,
  input logic        rst_n,
  input logic        clear,
  clq_store_if.slave bus
);

  clq_state_e       state_q, state_d;
  cla_t             cla_q;
  ptr_t             new_q;
  slot_t            slot_q;
  logic [NF_W-1:0]  next_free_q;
  node_t            node_mem [NODE_DEPTH];

  logic  full;
  logic  ready;
  logic  accept;
  lit_t  cur_lit;
  logic  skip;
  logic  link_en;
  ptr_t  rd_head;
  ptr_t  rd_tail;
  slot_t rd_tail_slot;
  tidx_t cur_idx;

  assign full    = (next_free_q == NF_W'(NODE_DEPTH));
  assign accept  = bus.carb2clq_valid && ready;
  assign cur_lit = cla_q[slot_q];
  assign cur_idx = lit_idx(cur_lit);
  assign link_en = (state_q == LINK) && !skip;

  // Repeated literals inside one clause are linked only at their first slot.
  always_comb begin
    skip = (cur_lit == '0);
    for (int unsigned j = 0; j < CLA_LENGTH; j++) begin
      if (SLOT_W'(j) < slot_q && cla_q[j] == cur_lit) skip = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = !full && !clear;
        if (bus.carb2clq_valid && ready) state_d = LINK;
      end
      LINK: begin
        if (slot_q == SLOT_W'(CLA_LENGTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q     <= IDLE;
      cla_q       <= '0;
      new_q       <= '0;
      slot_q      <= '0;
      next_free_q <= NF_W'(1);
    end else begin
      state_q <= state_d;
      if (accept) begin
        cla_q       <= bus.carb2clq_cla;
        new_q       <= ptr_t'(next_free_q);
        next_free_q <= next_free_q + 1'b1;
        slot_q      <= '0;
      end else if (state_q == LINK) begin
        slot_q <= slot_q + 1'b1;
      end
    end
  end

  // Node storage is not cleared: freed nodes become unreachable once heads are zeroed.
  always_ff @(posedge clk) begin
    if (rst_n && !clear) begin
      if (accept) begin
        node_mem[ptr_t'(next_free_q)] <= '{cla: bus.carb2clq_cla, ptr: '0};
      end else if (link_en && rd_tail != '0) begin
        node_mem[rd_tail].ptr[rd_tail_slot] <= new_q;
      end
    end
  end

  clq_lit_table u_lit_table (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .rd_head_idx  (lit_idx(bus.bcp2clq_lit)),
    .rd_head      (rd_head),
    .rd_tail_idx  (cur_idx),
    .rd_tail      (rd_tail),
    .rd_tail_slot (rd_tail_slot),
    .we           (link_en),
    .wr_idx       (cur_idx),
    .wr_head      (rd_tail == '0),
    .wr_ptr       (new_q),
    .wr_slot      (slot_q)
  );

  always_comb begin
    bus.clq2bcp_init_ptr = '0;
    if (bus.bcp2clq_lit != '0) bus.clq2bcp_init_ptr = rd_head;
  end

  assign bus.clq2bcp_init_ptr_valid = (bus.clq2bcp_init_ptr != '0);

  always_comb begin
    bus.node = '0;
    if (bus.node_ptr != '0 && 32'(bus.node_ptr) < NODE_DEPTH) bus.node = node_mem[bus.node_ptr];
  end

  assign bus.clq2carb_ready = ready;
  assign bus.halt           = (state_q == LINK);
  assign bus.full           = full;

endmodule
